msx_mouse_port: RTL and testbench

- Downstream consumer of the PS/2 mouse decoder.
- Accumulates per-packet X/Y deltas into saturating signed counters.
- Serves the accumulated counts to the MSX joystick port using the MSX mouse nibble protocol: pin-8 strobe toggles, four nibbles are returned on pins 1-4, and buttons appear on the trigger pins.
- Sits between the PS/2 mouse decoder and the joystick-port multiplexer.

---
 rtl/msx_mouse_port.sv | 176 +++++++++++++++++
 tb/tb_msx_mouse_port.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/msx_mouse_port.sv
// msx_mouse_port
//   Collects X/Y movement from the PS/2 mouse decoder into saturating signed
//   8-bit accumulators and returns them to an MSX joystick port with the MSX
//   mouse nibble protocol. Every strobe (pin 8) edge advances a 4-step phase:
//   X high nibble, X low nibble, Y high nibble, Y low nibble. The accumulators
//   are snapshotted and cleared when X high is returned. Buttons appear on the
//   trigger pins.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   enable     in   mouse mode selected on this port (0 = port idle)
//   dx, dy     in   signed per-packet deltas, valid with dvalid
//   dvalid     in   one-cycle delta strobe
//   mleft_n    in   left button, active-low
//   mright_n   in   right button, active-low
//   strobe     in   joystick pin 8, asynchronous to clk
//   nibble_out out  joystick pins 1-4 (bit0 up .. bit3 right)
//   trig_a_n   out  trigger A (left button), active-low
//   trig_b_n   out  trigger B (right button), active-low
//
// Phase FSM
//   state    | meaning
//   PH_X_HI  | idle / next edge snapshots and returns X[7:4]
//   PH_X_LO  | next edge returns snapshot X[3:0]
//   PH_Y_HI  | next edge returns snapshot Y[7:4]
//   PH_Y_LO  | next edge returns snapshot Y[3:0], then back to PH_X_HI

module msx_mouse_port #(
    parameter int TIMEOUT = 40000,
    parameter int TO_W    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] dx,
    input  logic [7:0] dy,
    input  logic       dvalid,
    input  logic       mleft_n,
    input  logic       mright_n,
    input  logic       strobe,
    output logic [3:0] nibble_out,
    output logic       trig_a_n,
    output logic       trig_b_n
);

    typedef enum logic [1:0] {
        PH_X_HI = 2'd0,
        PH_X_LO = 2'd1,
        PH_Y_HI = 2'd2,
        PH_Y_LO = 2'd3
    } phase_t;

    phase_t            phase_q, phase_d;
    logic              strb_s1_q, strb_s2_q, strb_s3_q;
    logic [TO_W-1:0]   to_q, to_d;
    logic [7:0]        acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [7:0]        snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic [3:0]        nibble_q, nibble_d;
    logic              trig_a_q, trig_a_d, trig_b_q, trig_b_d;

    logic              strb_edge;
    logic              to_hit;
    logic              take_snap;

    // Edges are only acted on in mouse mode; the synchroniser keeps tracking
    // the pin while disabled so re-enabling produces no spurious edge.
    assign strb_edge = enable & (strb_s2_q ^ strb_s3_q);
    assign to_hit    = (to_q == TO_W'(TIMEOUT));
    assign take_snap = strb_edge & (phase_q == PH_X_HI);

    // Signed add computed at 9 bits; an overflow shows up as bit 8 != bit 7.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (s[8] != s[7]) begin
            return s[8] ? 8'h80 : 8'h7F;
        end
        return s[7:0];
    endfunction

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_X_HI;
            to_q      <= '0;
            strb_s1_q <= 1'b0;
            strb_s2_q <= 1'b0;
            strb_s3_q <= 1'b0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            snap_x_q  <= '0;
            snap_y_q  <= '0;
            nibble_q  <= 4'h0;
            trig_a_q  <= 1'b1;
            trig_b_q  <= 1'b1;
        end else begin
            phase_q   <= phase_d;
            to_q      <= to_d;
            strb_s1_q <= strobe;
            strb_s2_q <= strb_s1_q;
            strb_s3_q <= strb_s2_q;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            snap_x_q  <= snap_x_d;
            snap_y_q  <= snap_y_d;
            nibble_q  <= nibble_d;
            trig_a_q  <= trig_a_d;
            trig_b_q  <= trig_b_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        phase_d = phase_q;
        if (!enable) begin
            phase_d = PH_X_HI;
        end else if (strb_edge) begin
            case (phase_q)
                PH_X_HI: phase_d = PH_X_LO;
                PH_X_LO: phase_d = PH_Y_HI;
                PH_Y_HI: phase_d = PH_Y_LO;
                default: phase_d = PH_X_HI;
            endcase
        end else if ((phase_q != PH_X_HI) && to_hit) begin
            phase_d = PH_X_HI;
        end
    end

    // Inactivity timer: cleared by any edge, idle at 0 in PH_X_HI.
    always_comb begin
        to_d = '0;
        if (enable && !strb_edge && (phase_q != PH_X_HI) && !to_hit) begin
            to_d = to_q + TO_W'(1);
        end
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        nibble_d = nibble_q;
        trig_a_d = 1'b1;
        trig_b_d = 1'b1;
        if (!enable) begin
            nibble_d = 4'hF;
        end else begin
            trig_a_d = mleft_n;
            trig_b_d = mright_n;
            if (strb_edge) begin
                case (phase_q)
                    PH_X_HI: nibble_d = acc_x_q[7:4];
                    PH_X_LO: nibble_d = snap_x_q[3:0];
                    PH_Y_HI: nibble_d = snap_y_q[7:4];
                    default: nibble_d = snap_y_q[3:0];
                endcase
            end
        end
    end

    // Accumulators. On a snapshot the pre-delta value is captured and a
    // coincident delta starts the next accumulation instead of being lost.
    always_comb begin
        snap_x_d = take_snap ? acc_x_q : snap_x_q;
        snap_y_d = take_snap ? acc_y_q : snap_y_q;
        acc_x_d  = take_snap ? 8'h00 : acc_x_q;
        acc_y_d  = take_snap ? 8'h00 : acc_y_q;
        if (dvalid) begin
            acc_x_d = sat_add(acc_x_d, dx);
            acc_y_d = sat_add(acc_y_d, dy);
        end
    end

    assign nibble_out = nibble_q;
    assign trig_a_n   = trig_a_q;
    assign trig_b_n   = trig_b_q;

endmodule

// File: tb/tb_msx_mouse_port.sv
// tb_msx_mouse_port
//   Directed bench for msx_mouse_port with hand-computed nibble sequences.
//   A short TIMEOUT keeps the inactivity case quick.

module tb_msx_mouse_port;

    localparam int TIMEOUT = 50;
    localparam int TO_W    = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] dx, dy;
    logic       dvalid;
    logic       mleft_n, mright_n;
    logic       strobe;
    logic [3:0] nibble_out;
    logic       trig_a_n, trig_b_n;

    int n_cmp = 0;
    int n_bad = 0;

    msx_mouse_port #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .dx         (dx),
        .dy         (dy),
        .dvalid     (dvalid),
        .mleft_n    (mleft_n),
        .mright_n   (mright_n),
        .strobe     (strobe),
        .nibble_out (nibble_out),
        .trig_a_n   (trig_a_n),
        .trig_b_n   (trig_b_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] x, input logic [7:0] y);
        @(posedge clk); #1;
        dx = x; dy = y; dvalid = 1'b1;
        @(posedge clk); #1;
        dvalid = 1'b0;
    endtask

    // Strobe change lands 1 time unit after an edge; nibble updates on the
    // third following edge.
    task automatic toggle_read(input string tag, input logic [3:0] exp);
        @(posedge clk); #1;
        strobe = ~strobe;
        repeat (3) @(posedge clk);
        #1;
        chk(tag, {4'h0, nibble_out}, {4'h0, exp});
    endtask

    task automatic read4(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        toggle_read({tag, "_xh"}, a);
        toggle_read({tag, "_xl"}, b);
        toggle_read({tag, "_yh"}, c);
        toggle_read({tag, "_yl"}, d);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; dx = '0; dy = '0; dvalid = 1'b0;
        mleft_n = 1'b1; mright_n = 1'b1; strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nib", {4'h0, nibble_out}, 8'h00);
        chk("rst_ta", {7'h0, trig_a_n}, 8'h01);
        chk("rst_tb", {7'h0, trig_b_n}, 8'h01);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // basic read, then an empty read
        pulse(8'h05, 8'hFD);
        read4("rd1", 4'h0, 4'h5, 4'hF, 4'hD);
        read4("rd2", 4'h0, 4'h0, 4'h0, 4'h0);

        // saturation high and low
        for (int i = 0; i < 3; i++) pulse(8'h60, 8'h00);
        read4("sat_hi", 4'h7, 4'hF, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) pulse(8'hA0, 8'h00);
        read4("sat_lo", 4'h8, 4'h0, 4'h0, 4'h0);

        // timeout mid-transfer
        pulse(8'h12, 8'h00);
        toggle_read("to_xh", 4'h1);
        toggle_read("to_xl", 4'h2);
        repeat (TIMEOUT + 5) @(posedge clk);
        #1;
        chk("to_hold", {4'h0, nibble_out}, 8'h02);
        pulse(8'h34, 8'h00);
        read4("to_rst", 4'h3, 4'h4, 4'h0, 4'h0);

        // delta coincident with the phase-0 edge
        pulse(8'h02, 8'h00);
        @(posedge clk); #1;
        strobe = ~strobe;
        repeat (2) @(posedge clk);
        #1;
        dx = 8'h03; dy = 8'h00; dvalid = 1'b1;
        @(posedge clk); #1;
        dvalid = 1'b0;
        chk("co_xh", {4'h0, nibble_out}, 8'h00);
        toggle_read("co_xl", 4'h2);
        toggle_read("co_yh", 4'h0);
        toggle_read("co_yl", 4'h0);
        read4("co_next", 4'h0, 4'h3, 4'h0, 4'h0);

        // trigger latency
        @(posedge clk); #1;
        mleft_n = 1'b0; mright_n = 1'b1;
        @(negedge clk);
        chk("trg_early", {7'h0, trig_a_n}, 8'h01);
        @(posedge clk); #1;
        chk("trg_a", {7'h0, trig_a_n}, 8'h00);
        chk("trg_b", {7'h0, trig_b_n}, 8'h01);

        // disabled port
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("dis_nib", {4'h0, nibble_out}, 8'h0F);
        chk("dis_ta", {7'h0, trig_a_n}, 8'h01);
        chk("dis_tb", {7'h0, trig_b_n}, 8'h01);
        pulse(8'h21, 8'h00);
        toggle_read("dis_t1", 4'hF);
        toggle_read("dis_t2", 4'hF);
        toggle_read("dis_t3", 4'hF);
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("en_ta", {7'h0, trig_a_n}, 8'h00);
        read4("en_rd", 4'h2, 4'h1, 4'h0, 4'h0);

        // async reset between phase 1 and phase 2
        pulse(8'h10, 8'h00);
        toggle_read("ar_xh", 4'h1);
        toggle_read("ar_xl", 4'h0);
        pulse(8'h10, 8'h00);
        @(posedge clk); #1;
        reset_n = 1'b0;
        strobe = 1'b0;
        #1;
        chk("ar_nib", {4'h0, nibble_out}, 8'h00);
        chk("ar_ta", {7'h0, trig_a_n}, 8'h01);
        chk("ar_tb", {7'h0, trig_b_n}, 8'h01);
        repeat (2) @(posedge clk);
        #1;
        mleft_n = 1'b1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        read4("ar_rd", 4'h0, 4'h0, 4'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
